// File: rtl/prf_int_busy_table_pkg.sv
// Shared sizing constants and types for the integer physical-register busy table.
// Also provides the popcount helper used for the busy-register count.
package prf_int_busy_table_pkg;

    localparam int PRF_INT_SIZE       = 64;
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int IQ_INT_SIZE        = 32;
    localparam int DISPATCH_WIDTH     = 4;
    localparam int ISSUE_WIDTH_INT    = 3;

    typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_int_index_t;
    typedef logic [PRF_INT_SIZE-1:0]       prf_int_mask_t;
    typedef logic [PRF_INT_INDEX_SIZE:0]   prf_int_count_t;

    function automatic prf_int_count_t prf_int_popcount(input prf_int_mask_t vec);
        prf_int_count_t cnt;
        cnt = '0;
        for (int i = 0; i < PRF_INT_SIZE; i++) begin
            cnt = cnt + prf_int_count_t'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prf_int_busy_table_if.sv
// Bundle of set (rename/dispatch), clear (writeback) and query (issue queue)
// signals of the integer busy table; master drives requests, slave is the table.
interface prf_int_busy_table_if;
    import prf_int_busy_table_pkg::*;

    logic                                  clear_en;
    logic [DISPATCH_WIDTH-1:0]             alloc_valid;
    prf_int_index_t [DISPATCH_WIDTH-1:0]   alloc_index;
    logic [ISSUE_WIDTH_INT-1:0]            wb_valid;
    prf_int_index_t [ISSUE_WIDTH_INT-1:0]  wb_index;
    prf_int_index_t [IQ_INT_SIZE-1:0]      rs1_index;
    prf_int_index_t [IQ_INT_SIZE-1:0]      rs2_index;
    logic [IQ_INT_SIZE-1:0]                rs1_busy;
    logic [IQ_INT_SIZE-1:0]                rs2_busy;
    prf_int_count_t                        busy_count;

    modport master (
        output clear_en, alloc_valid, alloc_index, wb_valid, wb_index,
               rs1_index, rs2_index,
        input  rs1_busy, rs2_busy, busy_count
    );

    modport slave (
        input  clear_en, alloc_valid, alloc_index, wb_valid, wb_index,
               rs1_index, rs2_index,
        output rs1_busy, rs2_busy, busy_count
    );

endinterface

// File: rtl/prf_int_busy_table_decoder.sv
// Turns N (valid, index) pairs into a one-hot OR mask over all physical registers.
// Duplicate indices simply OR together.
module prf_int_busy_decoder
    import prf_int_busy_table_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           valid_i,
    input  prf_int_index_t [N-1:0] index_i,
    output prf_int_mask_t          mask_o
);

    generate
        for (genvar gi = 0; gi < PRF_INT_SIZE; gi++) begin : g_reg
            logic [N-1:0] hit;
            for (genvar gk = 0; gk < N; gk++) begin : g_port
                assign hit[gk] = valid_i[gk] && (index_i[gk] == prf_int_index_t'(gi));
            end
            assign mask_o[gi] = |hit;
        end
    endgenerate

endmodule

// File: rtl/prf_int_busy_table.sv
// Integer physical-register busy scoreboard: set on allocation, cleared on writeback.
// Define PRF_INT_BUSY_WB_BYPASS_EN to let same-cycle writebacks wake queries.
module prf_int_busy_table
    import prf_int_busy_table_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    prf_int_busy_table_if.slave   bus_if
);

    logic [PRF_INT_SIZE-1:1] busy_q;
    prf_int_mask_t           busy_vec;
    prf_int_mask_t           busy_d;
    prf_int_mask_t           set_mask;
    prf_int_mask_t           clr_mask;
    prf_int_mask_t           query_vec;
    prf_int_count_t          busy_count_q;
    prf_int_count_t          busy_count_d;

    prf_int_busy_decoder #(.N(DISPATCH_WIDTH)) u_alloc_dec (
        .valid_i (bus_if.alloc_valid),
        .index_i (bus_if.alloc_index),
        .mask_o  (set_mask)
    );

    prf_int_busy_decoder #(.N(ISSUE_WIDTH_INT)) u_wb_dec (
        .valid_i (bus_if.wb_valid),
        .index_i (bus_if.wb_index),
        .mask_o  (clr_mask)
    );

    // Register 0 has no storage: it is a constant-zero column of the table.
    assign busy_vec = {busy_q, 1'b0};

    // Set wins over clear: a reallocated register belongs to its new producer.
    always_comb begin
        busy_d       = set_mask | (busy_vec & ~clr_mask);
        busy_d[0]    = 1'b0;
        busy_count_d = prf_int_popcount(busy_d);
    end

    always_ff @(posedge clock) begin
        if (reset || bus_if.clear_en) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d[PRF_INT_SIZE-1:1];
            busy_count_q <= busy_count_d;
        end
    end

`ifdef PRF_INT_BUSY_WB_BYPASS_EN
    assign query_vec = busy_vec & ~clr_mask;
`else
    assign query_vec = busy_vec;
`endif

    generate
        for (genvar gi = 0; gi < IQ_INT_SIZE; gi++) begin : g_query
            assign bus_if.rs1_busy[gi] = query_vec[bus_if.rs1_index[gi]];
            assign bus_if.rs2_busy[gi] = query_vec[bus_if.rs2_index[gi]];
        end
    endgenerate

    assign bus_if.busy_count = busy_count_q;

endmodule

// File: tb/tb_prf_int_busy_table.sv
// Directed and model-checked stimulus for the integer busy table.
module tb_prf_int_busy_table;
    import prf_int_busy_table_pkg::*;

`ifdef PRF_INT_BUSY_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    // Query result for a busy register being written back in the same cycle.
    localparam logic WB_SAME_CYCLE_BUSY = ~BYPASS;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    prf_int_busy_table_if bus_if();

    prf_int_busy_table dut (
        .clock  (clock),
        .reset  (reset),
        .bus_if (bus_if.slave)
    );

    task automatic idle();
        bus_if.clear_en    = 1'b0;
        bus_if.alloc_valid = '0;
        bus_if.alloc_index = '0;
        bus_if.wb_valid    = '0;
        bus_if.wb_index    = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_linear_queries();
        for (int s = 0; s < IQ_INT_SIZE; s++) begin
            bus_if.rs1_index[s] = prf_int_index_t'(s);
            bus_if.rs2_index[s] = prf_int_index_t'(63 - s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_linear_queries();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus_if.rs1_busy !== 32'h0) begin
            n_err++; $display("FAIL reset_rs1: got %h expected %h", bus_if.rs1_busy, 32'h0);
        end
        n_vec++;
        if (bus_if.rs2_busy !== 32'h0) begin
            n_err++; $display("FAIL reset_rs2: got %h expected %h", bus_if.rs2_busy, 32'h0);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", bus_if.busy_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_alloc();
        bus_if.alloc_valid    = 4'b1111;
        bus_if.alloc_index[0] = 6'd5;
        bus_if.alloc_index[1] = 6'd6;
        bus_if.alloc_index[2] = 6'd7;
        bus_if.alloc_index[3] = 6'd0;
        bus_if.rs1_index[0]   = 6'd5;
        bus_if.rs1_index[1]   = 6'd6;
        bus_if.rs1_index[2]   = 6'd7;
        bus_if.rs1_index[3]   = 6'd0;
        #1;
        n_vec++;
        if (bus_if.rs1_busy[3:0] !== 4'b0000) begin
            n_err++; $display("FAIL alloc_same_cycle: got %b expected 0000", bus_if.rs1_busy[3:0]);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus_if.rs1_busy[3:0] !== 4'b0111) begin
            n_err++; $display("FAIL alloc_visible: got %b expected 0111", bus_if.rs1_busy[3:0]);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd3) begin
            n_err++; $display("FAIL alloc_count: got %0d expected 3", bus_if.busy_count);
        end
        $display("test_alloc done");
    endtask

    task automatic test_wb();
        bus_if.wb_valid    = 3'b001;
        bus_if.wb_index[0] = 6'd5;
        bus_if.rs1_index[0] = 6'd5;
        #1;
        n_vec++;
        if (bus_if.rs1_busy[0] !== WB_SAME_CYCLE_BUSY) begin
            n_err++; $display("FAIL wb_same_cycle: got %b expected %b", bus_if.rs1_busy[0], WB_SAME_CYCLE_BUSY);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus_if.rs1_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL wb_next_cycle: got %b expected 0", bus_if.rs1_busy[0]);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd2) begin
            n_err++; $display("FAIL wb_count: got %0d expected 2", bus_if.busy_count);
        end
        $display("test_wb done");
    endtask

    task automatic test_set_wins();
        bus_if.alloc_valid    = 4'b0001;
        bus_if.alloc_index[0] = 6'd9;
        tick();
        idle();
        #1;
        n_vec++;
        if (bus_if.busy_count !== 7'd3) begin
            n_err++; $display("FAIL setwin_pre_count: got %0d expected 3", bus_if.busy_count);
        end
        bus_if.alloc_valid    = 4'b0100;
        bus_if.alloc_index[2] = 6'd9;
        bus_if.wb_valid       = 3'b010;
        bus_if.wb_index[1]    = 6'd9;
        bus_if.rs1_index[0]   = 6'd9;
        #1;
        n_vec++;
        if (bus_if.rs1_busy[0] !== WB_SAME_CYCLE_BUSY) begin
            n_err++; $display("FAIL setwin_same_cycle: got %b expected %b", bus_if.rs1_busy[0], WB_SAME_CYCLE_BUSY);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus_if.rs1_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL setwin_busy: got %b expected 1", bus_if.rs1_busy[0]);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd3) begin
            n_err++; $display("FAIL setwin_count: got %0d expected 3", bus_if.busy_count);
        end
        $display("test_set_wins done");
    endtask

    task automatic test_clear();
        bus_if.alloc_valid    = 4'b0001;
        bus_if.alloc_index[0] = 6'd5;
        tick();
        idle();
        #1;
        n_vec++;
        if (bus_if.busy_count !== 7'd4) begin
            n_err++; $display("FAIL clear_pre_count: got %0d expected 4", bus_if.busy_count);
        end
        bus_if.clear_en       = 1'b1;
        bus_if.alloc_valid    = 4'b0001;
        bus_if.alloc_index[0] = 6'd12;
        tick();
        idle();
        bus_if.rs1_index[0] = 6'd5;
        bus_if.rs1_index[1] = 6'd6;
        bus_if.rs1_index[2] = 6'd7;
        bus_if.rs1_index[3] = 6'd12;
        bus_if.rs2_index[0] = 6'd9;
        #1;
        n_vec++;
        if (bus_if.rs1_busy[3:0] !== 4'b0000) begin
            n_err++; $display("FAIL clear_rs1: got %b expected 0000", bus_if.rs1_busy[3:0]);
        end
        n_vec++;
        if (bus_if.rs2_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL clear_rs2: got %b expected 0", bus_if.rs2_busy[0]);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd0) begin
            n_err++; $display("FAIL clear_count: got %0d expected 0", bus_if.busy_count);
        end
        $display("test_clear done");
    endtask

    task automatic test_dup_and_zero();
        bus_if.alloc_valid = 4'b1111;
        for (int k = 0; k < DISPATCH_WIDTH; k++) bus_if.alloc_index[k] = 6'd20;
        tick();
        idle();
        bus_if.rs1_index[0] = 6'd20;
        #1;
        n_vec++;
        if (bus_if.busy_count !== 7'd1 || bus_if.rs1_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL dup_alloc: got count=%0d busy=%b expected count=1 busy=1",
                              bus_if.busy_count, bus_if.rs1_busy[0]);
        end
        bus_if.alloc_valid    = 4'b0001;
        bus_if.alloc_index[0] = 6'd0;
        bus_if.wb_valid       = 3'b111;
        bus_if.wb_index[0]    = 6'd20;
        bus_if.wb_index[1]    = 6'd20;
        bus_if.wb_index[2]    = 6'd21;
        tick();
        idle();
        bus_if.rs1_index[1] = 6'd21;
        bus_if.rs1_index[2] = 6'd0;
        #1;
        n_vec++;
        if (bus_if.rs1_busy[2:0] !== 3'b000) begin
            n_err++; $display("FAIL dup_wb_busy: got %b expected 000", bus_if.rs1_busy[2:0]);
        end
        n_vec++;
        if (bus_if.busy_count !== 7'd0) begin
            n_err++; $display("FAIL dup_wb_count: got %0d expected 0", bus_if.busy_count);
        end
        $display("test_dup_and_zero done");
    endtask

    task automatic test_reset_override();
        bus_if.alloc_valid    = 4'b0001;
        bus_if.alloc_index[0] = 6'd30;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        bus_if.rs1_index[0] = 6'd30;
        #1;
        n_vec++;
        if (bus_if.busy_count !== 7'd0 || bus_if.rs1_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL reset_override: got count=%0d busy=%b expected count=0 busy=0",
                              bus_if.busy_count, bus_if.rs1_busy[0]);
        end
        $display("test_reset_override done");
    endtask

    task automatic test_random();
        prf_int_mask_t  model;
        prf_int_mask_t  set_m;
        prf_int_mask_t  clr_m;
        prf_int_mask_t  qv;
        logic [IQ_INT_SIZE-1:0] exp_rs1;
        logic [IQ_INT_SIZE-1:0] exp_rs2;
        prf_int_index_t r;
        int             exp_cnt;
        int             start_err;
        logic           flush;
        model     = '0;
        start_err = n_err;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            idle();
            set_m = '0;
            clr_m = '0;
            flush = ($urandom_range(0, 499) == 0);
            bus_if.clear_en = flush;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = prf_int_index_t'($urandom_range(1, 63));
                    if (!model[r] && !set_m[r]) begin
                        bus_if.alloc_valid[k] = 1'b1;
                        bus_if.alloc_index[k] = r;
                        set_m[r] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < ISSUE_WIDTH_INT; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = prf_int_index_t'($urandom_range(0, 63));
                    bus_if.wb_valid[k] = 1'b1;
                    bus_if.wb_index[k] = r;
                    clr_m[r] = 1'b1;
                end
            end
            for (int s = 0; s < IQ_INT_SIZE; s++) begin
                bus_if.rs1_index[s] = prf_int_index_t'($urandom_range(0, 63));
                bus_if.rs2_index[s] = prf_int_index_t'($urandom_range(0, 63));
            end
            qv = BYPASS ? (model & ~clr_m) : model;
            for (int s = 0; s < IQ_INT_SIZE; s++) begin
                exp_rs1[s] = qv[bus_if.rs1_index[s]];
                exp_rs2[s] = qv[bus_if.rs2_index[s]];
            end
            #1;
            n_vec++;
            if (bus_if.rs1_busy !== exp_rs1) begin
                n_err++; $display("FAIL rand_rs1 cyc %0d: got %h expected %h", cyc, bus_if.rs1_busy, exp_rs1);
            end
            n_vec++;
            if (bus_if.rs2_busy !== exp_rs2) begin
                n_err++; $display("FAIL rand_rs2 cyc %0d: got %h expected %h", cyc, bus_if.rs2_busy, exp_rs2);
            end
            tick();
            model = flush ? '0 : (set_m | (model & ~clr_m));
            model[0] = 1'b0;
            exp_cnt = 0;
            for (int i = 0; i < PRF_INT_SIZE; i++) exp_cnt += int'(model[i]);
            n_vec++;
            if (int'(bus_if.busy_count) != exp_cnt) begin
                n_err++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, bus_if.busy_count, exp_cnt);
            end
        end
        idle();
        $display("test_random done: %0d cycles, %0d new miscompares", 10000, n_err - start_err);
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_wb();
        test_set_wins();
        test_clear();
        test_dup_and_zero();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
